display_grid_pipe: RTL and testbench

DISPLAY_GRID_PIPE -- requirements
Module: display_grid_pipe

---
 rtl/display_grid_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_display_grid_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_grid_pipe.sv
// Two-stage pixel pipeline that draws a row of Simon buttons, a bounding box and
// font glyphs. Button lighting is sampled once per frame so the image never tears.
module display_grid_pipe #(
  parameter int NUM_BTN     = 4,
  parameter int BTN_SIZE    = 50,
  parameter int BTN_GAP     = 25,
  parameter int BTN_X0      = 315,
  parameter int BTN_Y0      = 250,
  parameter int HOLD_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [1:0]         state,
  input  logic [NUM_BTN-1:0] color,
  input  logic [3:0]         level,
  output logic [7:0]         vga_R,
  output logic [7:0]         vga_G,
  output logic [7:0]         vga_B,
  output logic               video_on,
  output logic               pix_valid_out
);
  localparam int PITCH  = BTN_SIZE + BTN_GAP;
  localparam int STAGES = 2;

  generate
    if (BTN_X0 + NUM_BTN*PITCH - BTN_GAP > 639) begin : g_bad_width
      $error("display_grid_pipe: button row extends past x=639");
    end
    if (NUM_BTN < 1 || NUM_BTN > 8) begin : g_bad_num
      $error("display_grid_pipe: NUM_BTN must be 1..8");
    end
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
      $error("display_grid_pipe: HOLD_FRAMES must be 1..255");
    end
  endgenerate

  typedef struct packed {
    logic       box;
    logic       btn;
    logic [2:0] idx;
    logic       gl;
    logic [1:0] gid;   // 0 L, 1 level digit, 2 S, 3 P
    logic [2:0] row;
    logic [2:0] col;
  } s1_t;

  function automatic logic [63:0] glyph(input logic [3:0] ch);
    case (ch)
      4'd0:    glyph = 64'h3C666E7666663C00;
      4'd1:    glyph = 64'h1838181818187E00;
      4'd2:    glyph = 64'h3C66060C30607E00;
      4'd3:    glyph = 64'h3C66061C06663C00;
      4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph = 64'h7E607C0606663C00;
      4'd6:    glyph = 64'h3C607C6666663C00;
      4'd7:    glyph = 64'h7E060C1830303000;
      4'd8:    glyph = 64'h3C66663C66663C00;
      4'd9:    glyph = 64'h3C66663E060C3800;
      4'd10:   glyph = 64'h6060606060607E00;
      4'd11:   glyph = 64'h3C66603C06663C00;
      4'd12:   glyph = 64'h7C66667C60606000;
      default: glyph = 64'h0;
    endcase
  endfunction

  function automatic logic [23:0] pal(input logic [2:0] idx, input logic lit);
    case (idx)
      3'd0:    pal = lit ? 24'hFF0000 : 24'h600000;
      3'd1:    pal = lit ? 24'hFFFF00 : 24'h7F7F30;
      3'd2:    pal = lit ? 24'h00FF00 : 24'h006000;
      3'd3:    pal = lit ? 24'h0000FF : 24'h000060;
      3'd4:    pal = lit ? 24'hFF00FF : 24'h600060;
      3'd5:    pal = lit ? 24'h00FFFF : 24'h006060;
      3'd6:    pal = lit ? 24'hFF8000 : 24'h603000;
      default: pal = lit ? 24'hFFFFFF : 24'h606060;
    endcase
  endfunction

  // ---------------- per-button hold counters and frame-latched lighting
  logic [NUM_BTN-1:0][7:0] hold_q, hold_d;
  logic [NUM_BTN-1:0]      lit_q, lit_d;
  logic [7:0]              frm_q;

  always_comb begin
    hold_d = hold_q;
    lit_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      lit_d[i] = |hold_q[i];
      if (state == 2'd0)                       hold_d[i] = 8'd0;
      else if (color[i])                       hold_d[i] = 8'(HOLD_FRAMES);
      else if (frame_start && hold_q[i] != '0) hold_d[i] = hold_q[i] - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= '0;
      lit_q  <= '0;
      frm_q  <= '0;
    end else begin
      hold_q <= hold_d;
      if (frame_start) begin
        lit_q <= lit_d;
        frm_q <= frm_q + 8'd1;
      end
    end
  end

  // ---------------- stage 1: region decode
  logic [NUM_BTN-1:0] btn_hit;
  logic               y_btn, box_hit, y_sm, y_lg;
  s1_t                s1_d, s1_q;

  assign y_btn = ({1'b0, pix_y} >= 11'(BTN_Y0)) && ({1'b0, pix_y} <= 11'(BTN_Y0 + BTN_SIZE));

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    localparam int XL = BTN_X0 + i*PITCH;
    assign btn_hit[i] = y_btn && ({1'b0, pix_x} >= 11'(XL)) && ({1'b0, pix_x} <= 11'(XL + BTN_SIZE));
  end

  assign box_hit = ((pix_x == 10'd250 || pix_x == 10'd650) && pix_y >= 10'd100 && pix_y <= 10'd450) ||
                   ((pix_y == 10'd100 || pix_y == 10'd450) && pix_x >= 10'd250 && pix_x <= 10'd650);
  assign y_sm = (pix_y >= 10'd112) && (pix_y <= 10'd127);
  assign y_lg = (pix_y >= 10'd192) && (pix_y <= 10'd223);

  // Glyph origins are aligned to 16 (scale 2) or 32 (scale 4), so the low
  // coordinate bits already are the offset inside the glyph.
  always_comb begin
    s1_d     = '0;
    s1_d.box = box_hit;
    s1_d.btn = |btn_hit;
    for (int i = NUM_BTN-1; i >= 0; i--) begin
      if (btn_hit[i]) s1_d.idx = 3'(i);
    end
    if (y_sm && pix_x >= 10'd256 && pix_x <= 10'd271) begin
      s1_d.gl = 1'b1; s1_d.gid = 2'd0; s1_d.row = pix_y[3:1]; s1_d.col = pix_x[3:1];
    end else if (y_sm && pix_x >= 10'd272 && pix_x <= 10'd287) begin
      s1_d.gl = 1'b1; s1_d.gid = 2'd1; s1_d.row = pix_y[3:1]; s1_d.col = pix_x[3:1];
    end else if (y_lg && pix_x >= 10'd416 && pix_x <= 10'd447) begin
      s1_d.gl = 1'b1; s1_d.gid = 2'd2; s1_d.row = pix_y[4:2]; s1_d.col = pix_x[4:2];
    end else if (y_lg && pix_x >= 10'd480 && pix_x <= 10'd511) begin
      s1_d.gl = 1'b1; s1_d.gid = 2'd3; s1_d.row = pix_y[4:2]; s1_d.col = pix_x[4:2];
    end
  end

  // ---------------- stage 2: colour
  logic [STAGES:1] vld_pipe_q;
  logic [7:0]      lit8, frow;
  logic [63:0]     gbits;
  logic [3:0]      ch;
  logic            show;
  logic [23:0]     rgb_d, rgb_q;
  logic            von_d, von_q;

  always_comb begin
    lit8              = '0;
    lit8[NUM_BTN-1:0] = lit_q;
    case (s1_q.gid)
      2'd0:    ch = 4'd10;
      2'd1:    ch = level;
      2'd2:    ch = 4'd11;
      default: ch = 4'd12;
    endcase
    show  = (s1_q.gid == 2'd0) || (s1_q.gid == 2'd1 && level <= 4'd9) ||
            (s1_q.gid == 2'd2 && state == 2'd1) || (s1_q.gid == 2'd3 && state == 2'd2);
    gbits = glyph(ch);
    frow  = gbits[{~s1_q.row, 3'b000} +: 8];
    rgb_d = '0;
    von_d = 1'b0;
    if (vld_pipe_q[1]) begin
      if (s1_q.box) begin
        von_d = 1'b1;
        rgb_d = (state == 2'd3 && frm_q[4]) ? 24'hFF0000 : 24'hFFFFFF;
      end else if (s1_q.btn) begin
        von_d = 1'b1;
        rgb_d = pal(s1_q.idx, lit8[s1_q.idx]);
      end else if (s1_q.gl && show && frow[~s1_q.col]) begin
        von_d = 1'b1;
        rgb_d = (s1_q.gid == 2'd1) ? 24'h00FF00 : 24'hFFFFFF;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      rgb_q      <= '0;
      von_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], pix_valid};
      s1_q       <= s1_d;
      rgb_q      <= rgb_d;
      von_q      <= von_d;
    end
  end

  assign vga_R         = rgb_q[23:16];
  assign vga_G         = rgb_q[15:8];
  assign vga_B         = rgb_q[7:0];
  assign video_on      = von_q;
  assign pix_valid_out = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_display_grid_pipe.sv
// Scoreboard bench for display_grid_pipe: a default instance plus an 8-button
// instance; expected pixels are queued at drive time and popped at output.
module tb_display_grid_pipe;
  logic       clk = 1'b0;
  logic       resetn, frame_start, pix_valid;
  logic [9:0] pix_x, pix_y;
  logic [1:0] state;
  logic [3:0] color_a, level;
  logic [7:0] color_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       von_a, pvo_a, von_b, pvo_b;

  always #5 clk = ~clk;

  display_grid_pipe dut_a (
    .clk(clk), .resetn(resetn), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .state(state), .color(color_a), .level(level),
    .vga_R(r_a), .vga_G(g_a), .vga_B(b_a), .video_on(von_a), .pix_valid_out(pvo_a));

  display_grid_pipe #(.NUM_BTN(8), .BTN_SIZE(30), .BTN_GAP(10), .BTN_X0(300)) dut_b (
    .clk(clk), .resetn(resetn), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .state(state), .color(color_b), .level(level),
    .vga_R(r_b), .vga_G(g_b), .vga_B(b_b), .video_on(von_b), .pix_valid_out(pvo_b));

  typedef struct { logic [23:0] rgb; logic von; int cyc; } exp_t;
  exp_t       qa[$], qb[$];
  exp_t       ea, eb;
  int         total = 0, bad = 0, cyc = 0;
  bit         mon_a = 1'b1, mon_b = 1'b0;
  logic [7:0] nframes;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn && mon_a) begin
      total++;
      if (pvo_a) begin
        if (qa.size() == 0) begin
          bad++; $display("FAIL out_a_unexpected got rgb=%h", {r_a, g_a, b_a});
        end else begin
          ea = qa.pop_front();
          if ({r_a, g_a, b_a, von_a} !== {ea.rgb, ea.von}) begin
            bad++; $display("FAIL pix_a got rgb=%h von=%b want rgb=%h von=%b", {r_a, g_a, b_a}, von_a, ea.rgb, ea.von);
          end
          total++;
          if (cyc - ea.cyc != 2) begin
            bad++; $display("FAIL latency_a got %0d want 2", cyc - ea.cyc);
          end
        end
      end else if ({r_a, g_a, b_a, von_a} !== 25'd0) begin
        bad++; $display("FAIL idle_a got rgb=%h von=%b want 0", {r_a, g_a, b_a}, von_a);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && mon_b) begin
      total++;
      if (pvo_b) begin
        if (qb.size() == 0) begin
          bad++; $display("FAIL out_b_unexpected got rgb=%h", {r_b, g_b, b_b});
        end else begin
          eb = qb.pop_front();
          if ({r_b, g_b, b_b, von_b} !== {eb.rgb, eb.von}) begin
            bad++; $display("FAIL pix_b got rgb=%h von=%b want rgb=%h von=%b", {r_b, g_b, b_b}, von_b, eb.rgb, eb.von);
          end
          total++;
          if (cyc - eb.cyc != 2) begin
            bad++; $display("FAIL latency_b got %0d want 2", cyc - eb.cyc);
          end
        end
      end else if ({r_b, g_b, b_b, von_b} !== 25'd0) begin
        bad++; $display("FAIL idle_b got rgb=%h von=%b want 0", {r_b, g_b, b_b}, von_b);
      end
    end
  end

  task automatic put(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb, input logic von, input bit to_b);
    exp_t e;
    e.rgb = rgb; e.von = von; e.cyc = cyc;
    pix_valid = 1'b1; pix_x = x; pix_y = y;
    if (to_b) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++; $display("FAIL drain_timeout pending a=%0d b=%0d want 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic chk(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb, input logic von);
    put(x, y, rgb, von, 1'b0);
    drain();
  endtask

  task automatic chk_b(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb, input logic von);
    put(x, y, rgb, von, 1'b1);
    drain();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    nframes++;
  endtask

  task automatic pulse_a(input int i);
    color_a = 4'(1 << i);
    @(negedge clk);
    color_a = '0;
  endtask

  task automatic test_reset();
    pix_valid = 1'b1; pix_x = 10'd320; pix_y = 10'd260;
    repeat (3) @(negedge clk);
    total++;
    if ({r_a, g_a, b_a, von_a, pvo_a, r_b, g_b, b_b, von_b, pvo_b} !== 52'd0) begin
      bad++; $display("FAIL reset_outputs got a=%h b=%h want 0", {r_a, g_a, b_a, von_a, pvo_a}, {r_b, g_b, b_b, von_b, pvo_b});
    end
    pix_valid = 1'b0;
    resetn    = 1'b1;
    nframes   = '0;
    @(negedge clk);
  endtask

  task automatic test_light();
    state = 2'd1;
    pulse_a(0);
    chk(10'd320, 10'd260, 24'h600000, 1'b1);
    frame();
    chk(10'd320, 10'd260, 24'hFF0000, 1'b1);
    chk(10'd315, 10'd250, 24'hFF0000, 1'b1);
    chk(10'd365, 10'd300, 24'hFF0000, 1'b1);
    chk(10'd366, 10'd260, 24'h000000, 1'b0);
    chk(10'd314, 10'd260, 24'h000000, 1'b0);
    chk(10'd320, 10'd301, 24'h000000, 1'b0);
    chk(10'd320, 10'd249, 24'h000000, 1'b0);
  endtask

  task automatic test_hold();
    for (int f = 2; f <= 9; f++) begin
      frame();
      chk(10'd320, 10'd260, (f <= 8) ? 24'hFF0000 : 24'h600000, 1'b1);
    end
  endtask

  task automatic test_same_cycle();
    state = 2'd1;
    color_a = 4'b0100; frame_start = 1'b1;
    @(negedge clk);
    color_a = '0; frame_start = 1'b0; nframes++;
    chk(10'd470, 10'd260, 24'h006000, 1'b1);
    for (int f = 1; f <= 9; f++) begin
      frame();
      chk(10'd470, 10'd260, (f <= 8) ? 24'h00FF00 : 24'h006000, 1'b1);
    end
  endtask

  task automatic test_idle();
    state = 2'd1;
    pulse_a(0);
    frame();
    chk(10'd320, 10'd260, 24'hFF0000, 1'b1);
    state = 2'd0;
    chk(10'd320, 10'd260, 24'hFF0000, 1'b1);
    frame();
    chk(10'd320, 10'd260, 24'h600000, 1'b1);
    chk(10'd100, 10'd50, 24'h000000, 1'b0);
  endtask

  task automatic test_back_to_back_glyph();
    logic [63:0] f7;
    logic        px;
    f7    = 64'h7E060C1830303000;
    state = 2'd0;
    level = 4'd7;
    for (int y = 112; y <= 127; y++)
      for (int x = 272; x <= 287; x++) begin
        px = f7[63 - 8*((y - 112) / 2) - (x - 272) / 2];
        put(10'(x), 10'(y), px ? 24'h00FF00 : 24'h000000, px, 1'b0);
      end
    drain();
    level = 4'd12;
    for (int y = 112; y <= 127; y++)
      for (int x = 272; x <= 287; x++) put(10'(x), 10'(y), 24'h000000, 1'b0, 1'b0);
    drain();
    level = 4'd7;
    chk(10'd258, 10'd112, 24'hFFFFFF, 1'b1);
    state = 2'd1;
    chk(10'd424, 10'd192, 24'hFFFFFF, 1'b1);
    chk(10'd484, 10'd192, 24'h000000, 1'b0);
    state = 2'd2;
    chk(10'd424, 10'd192, 24'h000000, 1'b0);
    chk(10'd484, 10'd192, 24'hFFFFFF, 1'b1);
  endtask

  task automatic test_blink();
    state = 2'd1;
    chk(10'd250, 10'd200, 24'hFFFFFF, 1'b1);
    chk(10'd650, 10'd450, 24'hFFFFFF, 1'b1);
    chk(10'd251, 10'd100, 24'hFFFFFF, 1'b1);
    chk(10'd250, 10'd99,  24'h000000, 1'b0);
    state = 2'd3;
    for (int k = 0; k < 300; k++) begin
      frame();
      if (k % 10 == 0) chk(10'd250, 10'd200, nframes[4] ? 24'hFF0000 : 24'hFFFFFF, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    state = 2'd1;
    pulse_a(0);
    frame();
    mon_a = 1'b0;
    pix_valid = 1'b1; pix_x = 10'd250; pix_y = 10'd200;
    repeat (3) @(negedge clk);
    total++;
    if ({r_a, g_a, b_a, von_a, pvo_a} !== {24'hFFFFFF, 2'b11}) begin
      bad++; $display("FAIL pre_reset_stream got %h want %h", {r_a, g_a, b_a, von_a, pvo_a}, {24'hFFFFFF, 2'b11});
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({r_a, g_a, b_a, von_a, pvo_a} !== 26'd0) begin
      bad++; $display("FAIL async_reset got %h want 0", {r_a, g_a, b_a, von_a, pvo_a});
    end
    @(negedge clk);
    resetn  = 1'b1;
    nframes = '0;
    @(negedge clk);
    total++;
    if ({r_a, g_a, b_a, von_a, pvo_a} !== 26'd0) begin
      bad++; $display("FAIL resume_cycle1 got %h want 0", {r_a, g_a, b_a, von_a, pvo_a});
    end
    @(negedge clk);
    total++;
    if ({r_a, g_a, b_a, von_a, pvo_a} !== {24'hFFFFFF, 2'b11}) begin
      bad++; $display("FAIL resume_cycle2 got %h want %h", {r_a, g_a, b_a, von_a, pvo_a}, {24'hFFFFFF, 2'b11});
    end
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    qa.delete();
    mon_a = 1'b1;
    chk(10'd320, 10'd260, 24'h600000, 1'b1);
    frame();
    chk(10'd320, 10'd260, 24'h600000, 1'b1);
  endtask

  task automatic test_wide();
    mon_a = 1'b0; mon_b = 1'b1;
    state = 2'd1;
    chk_b(10'd580, 10'd260, 24'h606060, 1'b1);
    chk_b(10'd610, 10'd260, 24'h606060, 1'b1);
    chk_b(10'd611, 10'd260, 24'h000000, 1'b0);
    chk_b(10'd579, 10'd260, 24'h000000, 1'b0);
    chk_b(10'd460, 10'd260, 24'h600060, 1'b1);
    chk_b(10'd459, 10'd260, 24'h000000, 1'b0);
    color_b = 8'h10;
    @(negedge clk);
    color_b = '0;
    frame();
    chk_b(10'd460, 10'd260, 24'hFF00FF, 1'b1);
    chk_b(10'd580, 10'd260, 24'h606060, 1'b1);
    repeat (3) @(negedge clk);
    mon_b = 1'b0;
    qa.delete();
    mon_a = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; state = 2'd0; color_a = '0; color_b = '0;
    level = 4'd0; nframes = '0;
    test_reset();
    test_light();
    test_hold();
    test_same_cycle();
    test_idle();
    test_back_to_back_glyph();
    test_blink();
    test_async_reset();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
